// File: rtl/if_stage.sv
// Instruction fetch stage: pre-IF PC select, IF register and ID handshake for a 1-cycle-latency inst SRAM.
// Optional IF_INST_BUF_EN adds a word buffer that holds the fetched instruction across ID stalls.
module if_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [63:0] if_to_id_bus,
  input  logic [32:0] id_to_if_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        to_if_valid;
  logic        if_valid;
  logic        if_ready_go;
  logic        if_allowin;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_pending;
  logic [31:0] br_target_r;
  logic        squash;
  logic        handshake;

  assign {br_taken, br_target} = id_to_if_bus;

  assign to_if_valid = resetn;
  assign seq_pc      = if_pc + 32'd4;
  assign nextpc      = br_pending ? br_target_r :
                       br_taken   ? br_target   : seq_pc;

  assign if_ready_go    = 1'b1;
  assign if_allowin     = ~if_valid | (if_ready_go & id_allowin);
  assign if_to_id_valid = if_valid & if_ready_go;
  assign handshake      = if_to_id_valid & id_allowin;

  // A branch that cannot be fetched now, or that supersedes an unissued one,
  // is parked in br_target_r and kills whatever IF holds or is loading.
  assign squash = br_taken & (~if_allowin | br_pending);

  assign inst_sram_en    = to_if_valid & if_allowin;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid    <= 1'b0;
      if_pc       <= 32'h1BFF_FFFC;
      br_pending  <= 1'b0;
      br_target_r <= 32'h0;
    end else begin
      if (squash) begin
        br_target_r <= br_target;
        br_pending  <= 1'b1;
      end else if (br_pending && inst_sram_en) begin
        br_pending  <= 1'b0;
      end

      if (squash) begin
        if_valid <= 1'b0;
      end else if (if_allowin) begin
        if_valid <= to_if_valid;
      end

      if (if_allowin) begin
        if_pc <= nextpc;
      end
    end
  end

`ifdef IF_INST_BUF_EN
  logic        inst_buf_valid;
  logic [31:0] inst_buf;

  // Capture on the first stalled cycle so the SRAM is free to change rdata while en=0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else if (squash || handshake) begin
      inst_buf_valid <= 1'b0;
    end else if (if_valid && !id_allowin && !inst_buf_valid) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= inst_sram_rdata;
    end
  end

  assign if_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;
`else
  assign if_inst = inst_sram_rdata;
`endif

  assign if_to_id_bus = {if_pc, if_inst};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stalls, branches, wrap and mid-stall reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [32:0] id_to_if_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        corrupt = 1'b0;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk(clk), .resetn(resetn), .id_allowin(id_allowin),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
    .id_to_if_bus(id_to_if_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // SRAM model: 1-cycle read; with the buffer build it trashes rdata while idle.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= word(inst_sram_addr);
`ifdef IF_INST_BUF_EN
    else if (corrupt) inst_sram_rdata <= 32'hDEAD_BEEF;
`endif
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; id_allowin = 1'b1; id_to_if_bus = 33'h0;
    next_cycle(); next_cycle();
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
    checks++; if (if_to_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_to_id_valid); end
    checks++; if (if_to_id_bus[63:32] !== 32'h1BFF_FFFC) begin errors++; $display("FAIL reset_pc got=%h exp=1bfffffc", if_to_id_bus[63:32]); end
    checks++; if (inst_sram_we !== 4'h0 || inst_sram_wdata !== 32'h0) begin errors++; $display("FAIL reset_we got=%h/%h exp=0/0", inst_sram_we, inst_sram_wdata); end
  endtask

  task automatic test_sequential();
    resetn = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_0000) begin errors++; $display("FAIL first_fetch got en=%b addr=%h exp en=1 addr=1c000000", inst_sram_en, inst_sram_addr); end
    checks++; if (if_to_id_valid !== 1'b0) begin errors++; $display("FAIL first_valid got=%b exp=0", if_to_id_valid); end
    next_cycle();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1C00_0000, word(32'h1C00_0000)}) begin errors++; $display("FAIL seq_bus0 got v=%b bus=%h exp v=1 bus=%h", if_to_id_valid, if_to_id_bus, {32'h1C00_0000, word(32'h1C00_0000)}); end
    checks++; if (inst_sram_addr !== 32'h1C00_0004 || inst_sram_en !== 1'b1) begin errors++; $display("FAIL seq_addr1 got=%h exp=1c000004", inst_sram_addr); end
    next_cycle();
    checks++; if (if_to_id_bus !== {32'h1C00_0004, word(32'h1C00_0004)} || inst_sram_addr !== 32'h1C00_0008) begin errors++; $display("FAIL seq_step2 got bus=%h addr=%h exp pc=1c000004 addr=1c000008", if_to_id_bus, inst_sram_addr); end
    next_cycle();
  endtask

  task automatic test_stall();
    logic [63:0] held;
    held = {32'h1C00_0008, word(32'h1C00_0008)};
    id_allowin = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_sram_en !== 1'b0 || if_to_id_valid !== 1'b1 || if_to_id_bus !== held) begin errors++; $display("FAIL stall_hold%0d got en=%b v=%b bus=%h exp en=0 v=1 bus=%h", i, inst_sram_en, if_to_id_valid, if_to_id_bus, held); end
      next_cycle();
    end
    id_allowin = 1'b1; #1;
    checks++; if (if_to_id_bus !== held || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_000C) begin errors++; $display("FAIL stall_release got bus=%h en=%b addr=%h exp bus=%h en=1 addr=1c00000c", if_to_id_bus, inst_sram_en, inst_sram_addr, held); end
    next_cycle();
    checks++; if (if_to_id_bus !== {32'h1C00_000C, word(32'h1C00_000C)} || inst_sram_addr !== 32'h1C00_0010) begin errors++; $display("FAIL stall_next got bus=%h addr=%h exp pc=1c00000c addr=1c000010", if_to_id_bus, inst_sram_addr); end
  endtask

  task automatic test_branch_now();
    id_to_if_bus = {1'b1, 32'h1C00_0100}; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_0100) begin errors++; $display("FAIL br_now_addr got en=%b addr=%h exp en=1 addr=1c000100", inst_sram_en, inst_sram_addr); end
    next_cycle();
    id_to_if_bus = 33'h0; #1;
    checks++; if (if_to_id_bus !== {32'h1C00_0100, word(32'h1C00_0100)} || inst_sram_addr !== 32'h1C00_0104) begin errors++; $display("FAIL br_now_next got bus=%h addr=%h exp pc=1c000100 addr=1c000104", if_to_id_bus, inst_sram_addr); end
    next_cycle();
    checks++; if (if_to_id_bus[63:32] !== 32'h1C00_0104 || inst_sram_addr !== 32'h1C00_0108) begin errors++; $display("FAIL br_now_seq got pc=%h addr=%h exp pc=1c000104 addr=1c000108", if_to_id_bus[63:32], inst_sram_addr); end
  endtask

  task automatic test_branch_stalled();
    id_allowin = 1'b0; id_to_if_bus = {1'b1, 32'h1C00_0200}; #1;
    checks++; if (inst_sram_en !== 1'b0) begin errors++; $display("FAIL br_st_en got=%b exp=0", inst_sram_en); end
    next_cycle();
    id_to_if_bus = 33'h0; #1;
    checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_0200) begin errors++; $display("FAIL br_st_issue got v=%b en=%b addr=%h exp v=0 en=1 addr=1c000200", if_to_id_valid, inst_sram_en, inst_sram_addr); end
    next_cycle();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1C00_0200, word(32'h1C00_0200)} || inst_sram_en !== 1'b0) begin errors++; $display("FAIL br_st_load got v=%b bus=%h en=%b exp v=1 pc=1c000200 en=0", if_to_id_valid, if_to_id_bus, inst_sram_en); end
    id_allowin = 1'b1; #1;
    checks++; if (inst_sram_addr !== 32'h1C00_0204) begin errors++; $display("FAIL br_st_cleared got addr=%h exp=1c000204", inst_sram_addr); end
    next_cycle();
  endtask

  task automatic test_double_branch();
    id_allowin = 1'b0; id_to_if_bus = {1'b1, 32'h1C00_0300}; #1;
    next_cycle();
    id_to_if_bus = {1'b1, 32'h1C00_0400}; #1;
    checks++; if (inst_sram_addr !== 32'h1C00_0300 || if_to_id_valid !== 1'b0) begin errors++; $display("FAIL dbl_first got addr=%h v=%b exp addr=1c000300 v=0", inst_sram_addr, if_to_id_valid); end
    next_cycle();
    id_to_if_bus = 33'h0; #1;
    checks++; if (if_to_id_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_0400) begin errors++; $display("FAIL dbl_win got v=%b en=%b addr=%h exp v=0 en=1 addr=1c000400", if_to_id_valid, inst_sram_en, inst_sram_addr); end
    next_cycle();
    id_allowin = 1'b1; #1;
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus !== {32'h1C00_0400, word(32'h1C00_0400)} || inst_sram_addr !== 32'h1C00_0404) begin errors++; $display("FAIL dbl_deliver got v=%b bus=%h addr=%h exp v=1 pc=1c000400 addr=1c000404", if_to_id_valid, if_to_id_bus, inst_sram_addr); end
    next_cycle();
  endtask

  task automatic test_inst_buf();
    logic [63:0] held;
    held = {32'h1C00_0404, word(32'h1C00_0404)};
    id_allowin = 1'b0; corrupt = 1'b1; #1;
    checks++; if (if_to_id_bus !== held) begin errors++; $display("FAIL buf_s0 got=%h exp=%h", if_to_id_bus, held); end
    next_cycle();
    checks++; if (if_to_id_bus !== held) begin errors++; $display("FAIL buf_s1 got=%h exp=%h", if_to_id_bus, held); end
    next_cycle();
    id_allowin = 1'b1; #1;
    checks++; if (if_to_id_bus !== held || inst_sram_addr !== 32'h1C00_0408) begin errors++; $display("FAIL buf_release got bus=%h addr=%h exp bus=%h addr=1c000408", if_to_id_bus, inst_sram_addr, held); end
    next_cycle();
    corrupt = 1'b0; #1;
    checks++; if (if_to_id_bus !== {32'h1C00_0408, word(32'h1C00_0408)}) begin errors++; $display("FAIL buf_after got=%h exp pc=1c000408 inst=%h", if_to_id_bus, word(32'h1C00_0408)); end
  endtask

  task automatic test_wrap();
    id_to_if_bus = {1'b1, 32'hFFFF_FFFC}; #1;
    next_cycle();
    id_to_if_bus = 33'h0; #1;
    checks++; if (if_to_id_bus[63:32] !== 32'hFFFF_FFFC || inst_sram_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap got pc=%h addr=%h exp pc=fffffffc addr=00000000", if_to_id_bus[63:32], inst_sram_addr); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    id_allowin = 1'b0; #1;
    next_cycle();
    id_to_if_bus = {1'b1, 32'h1C00_0500}; #1;
    next_cycle();
    id_to_if_bus = 33'h0;
    resetn = 1'b0; #1;
    checks++; if (inst_sram_en !== 1'b0 || if_to_id_valid !== 1'b0 || if_to_id_bus[63:32] !== 32'h1BFF_FFFC) begin errors++; $display("FAIL rst_mid got en=%b v=%b pc=%h exp en=0 v=0 pc=1bfffffc", inst_sram_en, if_to_id_valid, if_to_id_bus[63:32]); end
    next_cycle();
    id_allowin = 1'b1; resetn = 1'b1; #1;
    checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1C00_0000) begin errors++; $display("FAIL rst_mid_restart got en=%b addr=%h exp en=1 addr=1c000000", inst_sram_en, inst_sram_addr); end
    next_cycle();
    checks++; if (if_to_id_valid !== 1'b1 || if_to_id_bus[63:32] !== 32'h1C00_0000 || inst_sram_addr !== 32'h1C00_0004) begin errors++; $display("FAIL rst_mid_seq got v=%b pc=%h addr=%h exp v=1 pc=1c000000 addr=1c000004", if_to_id_valid, if_to_id_bus[63:32], inst_sram_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_now();
    test_branch_stalled();
    test_double_branch();
    test_inst_buf();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have these ports: clk  input  1  single clock, all state on rising edge.
REQ-002 The module SHALL have these ports: resetn  input  1  asynchronous, active-low reset.
REQ-003 The module SHALL have these ports: id_allowin  input  1  ID stage can accept an instruction this cycle.
REQ-004 The module SHALL have these ports: if_to_id_valid  output  1  IF holds a valid instruction for ID.
REQ-005 The module SHALL have these ports: if_to_id_bus  output  64  {if_pc[31:0], if_inst[31:0]}.
REQ-006 The module SHALL have these ports: id_to_if_bus  input  33  {br_taken, br_target[31:0]} from ID combinational logic.
REQ-007 The module SHALL have these ports: inst_sram_en, inst_sram_we[3:0], inst_sram_addr[31:0], inst_sram_wdata[31:0] outputs and inst_sram_rdata[31:0] input, for a synchronous SRAM with 1-cycle read latency.

Function
REQ-008 The pre-IF request SHALL be valid (to_if_valid=1) in every cycle where resetn=1.
REQ-009 seq_pc SHALL be if_pc+4, modulo 2^32 (0xFFFFFFFC+4 wraps to 0x00000000).
REQ-010 nextpc priority SHALL be: br_pending -> br_target_r; else br_taken -> br_target; else seq_pc.
REQ-011 The SRAM request SHALL be: inst_sram_en = to_if_valid & if_allowin; inst_sram_addr = nextpc; inst_sram_we = 4'h0; inst_sram_wdata = 32'h0.
REQ-012 if_ready_go SHALL be 1; if_allowin = ~if_valid | (if_ready_go & id_allowin); if_to_id_valid = if_valid & if_ready_go.
REQ-013 When if_allowin=1, the rising edge SHALL load if_valid <= to_if_valid and if_pc <= nextpc.
REQ-014 When br_taken=1 and if_allowin=1, the target SHALL be fetched in the same cycle, br_pending stays 0, and the wrong-path IF instruction moves to ID, which discards it.
REQ-015 When br_taken=1 and if_allowin=0, IF SHALL register br_target_r <= br_target and br_pending <= 1, and squash its held instruction (if_valid <= 0) on that edge.
REQ-016 br_pending SHALL clear on the edge where the pending target is issued (inst_sram_en=1), and that fetch SHALL use br_target_r.
REQ-017 A br_taken arriving while br_pending=1 SHALL overwrite br_target_r; the later branch wins.
REQ-018 if_inst SHALL be inst_sram_rdata, or the buffered word when the REQ-024 buffer is present and valid.
REQ-019 The ID stage SHALL see each instruction exactly once; a stall of N cycles on id_allowin SHALL hold if_to_id_bus constant for N+1 cycles.

Reset
REQ-020 While resetn=0 (asynchronous), the module SHALL hold if_valid=0, if_pc=32'h1BFFFFFC, br_pending=0, br_target_r=0 and inst_buf_valid=0.
REQ-021 While resetn=0, the outputs SHALL be if_to_id_valid=0 and inst_sram_en=0.
REQ-022 In the first cycle with resetn=1, the module SHALL drive inst_sram_en=1 and inst_sram_addr=32'h1C000000.
REQ-023 Reset asserted mid-stall or with a branch pending SHALL discard all state; no partial or pending fetch SHALL survive.

Configuration
REQ-024 With IF_INST_BUF_EN defined, a 32-bit buffer SHALL capture inst_sram_rdata on the first stalled cycle (if_valid & ~id_allowin & ~inst_buf_valid).
REQ-025 With IF_INST_BUF_EN defined, if_inst SHALL come from the buffer while inst_buf_valid=1.
REQ-026 With IF_INST_BUF_EN defined, inst_buf_valid SHALL clear on an IF->ID handshake, on a squash (REQ-015) or on reset; the SRAM may then change rdata while en=0.
REQ-027 Without IF_INST_BUF_EN, no buffer SHALL exist and if_inst SHALL be inst_sram_rdata; the SRAM must hold rdata while en=0.

Verification
REQ-028 Reset release, id_allowin=1 -> addr 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles; if_to_id_valid rises one cycle after the first en; bus pc=0x1C000000 with matching rdata.
REQ-029 id_allowin low for 3 cycles while pc=0x1C000008 -> inst_sram_en=0 and bus constant for 4 cycles; next fetch 0x1C00000C, with no duplicate or skipped instruction.
REQ-030 br_taken=1, target 0x1C000100, id_allowin=1 -> same-cycle addr 0x1C000100, then 0x1C000104; br_pending stays 0.
REQ-031 br_taken=1 pulse (target 0x1C000200) while id_allowin=0 -> if_to_id_valid=0 next cycle, then en=1 with addr 0x1C000200, and br_pending clears.
REQ-032 Two br_taken pulses (0x1C000300, then 0x1C000400) during a stall -> first post-stall fetch is 0x1C000400.
REQ-033 With IF_INST_BUF_EN: stall 2 cycles while the SRAM model corrupts rdata after the first stalled cycle -> ID receives the original word; without the macro, the bench holds rdata and gets the same result.
